fetch_stage: RTL and testbench

//  Instruction fetch stage directly downstream of the PC block: consumes pcCur, issues a

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues a word read for pcCur over a req/ack handshake and holds
// the returned instruction with its PC and PC+2 until decode consumes it.
module fetch_stage #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic [ADDR_W-1:0] pcCur,
  input  logic              fetchEn,
  input  logic              flush,
  input  logic              consume,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] instr,
  output logic              instrValid,
  output logic [ADDR_W-1:0] instrPc,
  output logic [ADDR_W-1:0] pcPlusTwo,
  output logic              fetchBusy,
  output logic              memErr
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     wait_cnt, cnt_nx;
  logic              req_nx, vld_nx, err_nx, launch;
  logic [ADDR_W-1:0] addr_nx, ipc_nx, pc2_nx;
  logic [DATA_W-1:0] instr_nx;

  assign fetchBusy = (state == WAIT) | ((state == FULL) & ~consume);

  always_comb begin
    state_nx = state;
    cnt_nx   = wait_cnt;
    req_nx   = memReq;
    addr_nx  = memAddr;
    vld_nx   = instrValid;
    err_nx   = memErr;
    ipc_nx   = instrPc;
    pc2_nx   = pcPlusTwo;
    instr_nx = instr;
    launch   = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      vld_nx   = 1'b0;
      req_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: launch = fetchEn;
        WAIT: begin
          if (memAck) begin
            instr_nx = memData;
            ipc_nx   = memAddr;
            pc2_nx   = memAddr + ADDR_W'(2);
            vld_nx   = 1'b1;
            req_nx   = 1'b0;
            state_nx = FULL;
          end else if (wait_cnt == CW'(MAX_WAIT)) begin
            err_nx   = 1'b1;
            req_nx   = 1'b0;
            state_nx = IDLE;
          end else begin
            cnt_nx = wait_cnt + CW'(1);
          end
        end
        FULL: begin
          if (consume) begin
            vld_nx   = 1'b0;
            state_nx = IDLE;
            launch   = fetchEn;
          end
        end
        default: state_nx = IDLE;
      endcase
      // Odd PCs never reach memory; they only raise the sticky error.
      if (launch) begin
        if (pcCur[0]) begin
          err_nx = 1'b1;
        end else begin
          addr_nx  = pcCur;
          req_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = WAIT;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      memReq     <= 1'b0;
      memAddr    <= '0;
      instr      <= '0;
      instrValid <= 1'b0;
      instrPc    <= '0;
      pcPlusTwo  <= '0;
      memErr     <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= cnt_nx;
      memReq     <= req_nx;
      memAddr    <= addr_nx;
      instr      <= instr_nx;
      instrValid <= vld_nx;
      instrPc    <= ipc_nx;
      pcPlusTwo  <= pc2_nx;
      memErr     <= err_nx;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_fetch_stage;
  localparam int MAX_WAIT = 15;

  logic        clock = 1'b0;
  logic        resetN, fetchEn, flush, consume, memAck;
  logic [15:0] pcCur, memData;
  logic        memReq, instrValid, fetchBusy, memErr;
  logic [15:0] memAddr, instr, instrPc, pcPlusTwo;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fetch_stage #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .resetN(resetN), .pcCur(pcCur), .fetchEn(fetchEn), .flush(flush),
    .consume(consume), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memData(memData), .instr(instr), .instrValid(instrValid), .instrPc(instrPc),
    .pcPlusTwo(pcPlusTwo), .fetchBusy(fetchBusy), .memErr(memErr)
  );

  always #5 clock = ~clock;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a request is outstanding (with its age) or an instruction is held, or neither.
  bit          m_out, m_hold, m_err;
  int          m_age;
  logic [15:0] m_addr, m_instr, m_ipc;

  always @(posedge clock) begin
    if (!resetN) begin
      m_out <= 0; m_hold <= 0; m_err <= 0; m_age <= 0;
      m_addr <= '0; m_instr <= '0; m_ipc <= '0;
    end else if (flush) begin
      m_out <= 0; m_hold <= 0;
    end else if (m_out) begin
      if (memAck) begin
        m_out <= 0; m_hold <= 1; m_instr <= memData; m_ipc <= m_addr;
      end else if (m_age == MAX_WAIT) begin
        m_out <= 0; m_err <= 1;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      if (m_hold && consume) m_hold <= 0;
      if (fetchEn && (!m_hold || consume)) begin
        if (pcCur[0]) m_err <= 1;
        else begin
          m_out <= 1; m_age <= 0; m_addr <= pcCur;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic [15:0] pc2;
      pc2 = m_ipc + 16'd2;
      check("memReq", {31'd0, memReq}, {31'd0, m_out});
      check("instrValid", {31'd0, instrValid}, {31'd0, m_hold});
      check("memErr", {31'd0, memErr}, {31'd0, m_err});
      check("fetchBusy", {31'd0, fetchBusy}, {31'd0, m_out | (m_hold & ~consume)});
      if (m_out) check("memAddr", {16'd0, memAddr}, {16'd0, m_addr});
      if (m_hold) begin
        check("instr", {16'd0, instr}, {16'd0, m_instr});
        check("instrPc", {16'd0, instrPc}, {16'd0, m_ipc});
        check("pcPlusTwo", {16'd0, pcPlusTwo}, {16'd0, pc2});
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      #1;
    end
  endtask

  initial begin
    int hi;
    resetN = 0; fetchEn = 1; memAck = 1; memData = 16'h5555; pcCur = 16'h0010;
    flush = 0; consume = 0;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_instrValid", {31'd0, instrValid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_memErr", {31'd0, memErr}, 32'd0);
    resetN = 1; fetchEn = 0; memAck = 0;
    cyc(1);

    // Basic fetch with ack in the 4th request cycle
    pcCur = 16'h0010; fetchEn = 1;
    cyc(1);
    fetchEn = 0;
    check("t2_addr", {16'd0, memAddr}, 32'h0010);
    cyc(3);
    check("t2_addr_held", {16'd0, memAddr}, 32'h0010);
    memAck = 1; memData = 16'hABCD;
    cyc(1);
    memAck = 0;
    check("t2_instr", {16'd0, instr}, 32'hABCD);
    check("t2_pc", {16'd0, instrPc}, 32'h0010);
    check("t2_pc2", {16'd0, pcPlusTwo}, 32'h0012);
    check("t2_vld", {31'd0, instrValid}, 32'd1);
    check("t2_busy", {31'd0, fetchBusy}, 32'd1);
    cyc(2);

    // Back-to-back consume + fetch
    consume = 1; fetchEn = 1; pcCur = 16'h0012;
    #1 check("t3_busy_consume", {31'd0, fetchBusy}, 32'd0);
    cyc(1);
    consume = 0; fetchEn = 0;
    check("t3_req", {31'd0, memReq}, 32'd1);
    check("t3_addr", {16'd0, memAddr}, 32'h0012);
    check("t3_vld", {31'd0, instrValid}, 32'd0);
    memAck = 1; memData = 16'h1234;
    cyc(1);
    memAck = 0;
    check("t3_instr", {16'd0, instr}, 32'h1234);
    consume = 1;
    cyc(1);
    consume = 0;

    // PC+2 wrap
    pcCur = 16'hFFFE; fetchEn = 1;
    cyc(1);
    fetchEn = 0; memAck = 1; memData = 16'h0F0F;
    cyc(1);
    memAck = 0;
    check("t4_pc", {16'd0, instrPc}, 32'hFFFE);
    check("t4_pc2", {16'd0, pcPlusTwo}, 32'h0000);
    consume = 1;
    cyc(1);
    consume = 0;

    // Flush together with ack, then a normal fetch, then flush while full
    pcCur = 16'h0040; fetchEn = 1;
    cyc(1);
    fetchEn = 0;
    cyc(1);
    flush = 1; memAck = 1; memData = 16'hDEAD; fetchEn = 1; pcCur = 16'h0044;
    cyc(1);
    flush = 0; memAck = 0; fetchEn = 0;
    check("t5_vld", {31'd0, instrValid}, 32'd0);
    check("t5_req", {31'd0, memReq}, 32'd0);
    cyc(1);
    pcCur = 16'h0020; fetchEn = 1;
    cyc(1);
    fetchEn = 0; memAck = 1; memData = 16'h7777;
    cyc(1);
    memAck = 0;
    check("t5_instr", {16'd0, instr}, 32'h7777);
    check("t5_pc", {16'd0, instrPc}, 32'h0020);
    flush = 1;
    cyc(1);
    flush = 0;
    check("t5_flush_full", {31'd0, instrValid}, 32'd0);
    check("t5_noerr", {31'd0, memErr}, 32'd0);

    // Timeout: request held MAX_WAIT+1 cycles
    pcCur = 16'h0030; fetchEn = 1;
    cyc(1);
    fetchEn = 0;
    hi = memReq ? 1 : 0;
    for (int i = 0; i < 40 && memReq; i++) begin
      cyc(1);
      if (memReq) hi++;
    end
    check("t6_req_cycles", hi, 32'd16);
    check("t6_err", {31'd0, memErr}, 32'd1);
    pcCur = 16'h0003; fetchEn = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t6_misalign_req", {31'd0, memReq}, 32'd0);
    end
    fetchEn = 0;
    check("t6_err_sticky", {31'd0, memErr}, 32'd1);

    // Reset mid-wait, late ack ignored
    pcCur = 16'h0050; fetchEn = 1;
    cyc(1);
    fetchEn = 0;
    resetN = 0;
    cyc(1);
    resetN = 1; memAck = 1; memData = 16'hBEEF;
    check("t7_req", {31'd0, memReq}, 32'd0);
    cyc(1);
    memAck = 0;
    check("t7_vld", {31'd0, instrValid}, 32'd0);
    check("t7_err", {31'd0, memErr}, 32'd0);
    cyc(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
